// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: runs one clear/feed/drain/read-out dot-product job per start on a 1-D PE chain
module systolic_array_ctrl #(
    parameter int PE_NUMBER = 64,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic [LEN_W-1:0] w_row,
    output logic             w_valid,
    output logic             arr_reset,
    output logic             arr_read,
    output logic [15:0]      arr_l_d_i,
    input  logic [15:0]      arr_l_d_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last
);
    localparam int CW = $clog2(PE_NUMBER) + 1;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READ, DONE} state_t;
    state_t state;
    logic [LEN_W-1:0] len_q, feed_cnt, feed_nxt;
    logic [CW-1:0] cnt;
    logic run, feed, rd, last;
    // Everything except arr_reset is forced low while reset is held
    assign run = !reset;
    assign feed = run && state == FEED;
    assign rd = run && state == READ;
    assign last = cnt == CW'(PE_NUMBER - 1);
    assign feed_nxt = feed_cnt + 1'b1;
    assign busy = run && state != IDLE;
    assign done = run && state == DONE;
    assign arr_reset = reset || state == CLEAR;
    assign in_ready = feed;
    assign w_row = feed ? feed_cnt : '0;
    assign w_valid = feed && in_valid;
    assign arr_l_d_i = w_valid ? in_data : '0;
    assign out_valid = rd;
    assign out_data = rd ? arr_l_d_o : '0;
    assign out_last = rd && last;
    assign arr_read = rd && out_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            len_q <= '0;
            feed_cnt <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_q <= len;
                    state <= CLEAR;
                end
                CLEAR: begin
                    feed_cnt <= '0;
                    cnt <= '0;
                    state <= len_q != '0 ? FEED : DRAIN;
                end
                FEED: if (in_valid) begin
                    feed_cnt <= feed_nxt == len_q ? '0 : feed_nxt;
                    state <= feed_nxt == len_q ? DRAIN : FEED;
                end
                DRAIN: begin
                    cnt <= cnt == CW'(PE_NUMBER - 2) ? '0 : cnt + 1'b1;
                    state <= cnt == CW'(PE_NUMBER - 2) ? READ : DRAIN;
                end
                READ: if (out_ready) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    state <= last ? DONE : READ;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl: scoreboard bench driving the controller against a small 4-PE array model
`timescale 1ns/1ps
module tb_systolic_array_ctrl;
    logic clk, reset, start, busy, done, in_valid, in_ready, w_valid;
    logic arr_reset, arr_read, out_valid, out_ready, out_last;
    logic [7:0] len, w_row;
    logic [15:0] in_data, arr_l_d_i, arr_l_d_o, out_data;
    int pass = 0, total = 0;
    logic [16:0] sb[$];
    logic [16:0] e;
    logic [15:0] smp[0:7];
    logic [31:0] vmask, rmask;
    logic [15:0] wbuf[0:255];
    logic [15:0] prod, p[0:3], acc[0:3];

    systolic_array_ctrl #(.PE_NUMBER(4), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .w_row(w_row),
        .w_valid(w_valid), .arr_reset(arr_reset), .arr_read(arr_read),
        .arr_l_d_i(arr_l_d_i), .arr_l_d_o(arr_l_d_o), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Array model: products ripple one PE per cycle, PE i scales its sum by i+1
    assign prod = arr_l_d_i * (w_valid ? wbuf[w_row] : 16'd0);
    assign arr_l_d_o = acc[0];
    always @(posedge clk) begin
        if (arr_reset) begin
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
                p[i] <= '0;
            end
        end else if (arr_read) begin
            for (int i = 0; i < 3; i++) acc[i] <= acc[i+1];
            acc[3] <= '0;
        end else begin
            acc[0] <= acc[0] + prod;
            p[0] <= prod;
            for (int i = 1; i < 4; i++) begin
                acc[i] <= acc[i] + p[i-1] * 16'(i + 1);
                p[i] <= p[i-1];
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_word", 32'(out_data), 32'hffff_ffff);
            else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[16:1]));
                chk("out_last", 32'(out_last), 32'(e[0]));
            end
        end
    end

    task automatic job(input logic [7:0] n, input logic [15:0] dot, input int exp_done,
                       input int exp_feed, input int exp_read, input bit poke);
        int si, cyc, fc, dc, rc, vi, ri;
        bit seen, stall;
        logic [15:0] prev;
        si = 0; cyc = 0; fc = 0; dc = 0; rc = 0; vi = 0; ri = 0; seen = 0; stall = 0; prev = 0;
        for (int i = 0; i < 4; i++) sb.push_back({16'(dot * 16'(i + 1)), i == 3});
        @(posedge clk); #1;
        start = 1; len = n;
        @(posedge clk); #1;
        len = 8'd200;
        cyc = 1;
        while (!seen && cyc < 200) begin
            start = 0; in_valid = 0; in_data = 16'h7777; out_ready = 1;
            if (in_ready) begin
                in_valid = vmask[vi];
                vi++;
                if (in_valid) in_data = smp[si];
                if (poke && vi == 2) begin start = 1; len = 8'd5; end
            end
            if (out_valid) begin
                out_ready = rmask[ri];
                ri++;
                if (poke && ri == 2) begin start = 1; len = 8'd5; end
            end
            @(negedge clk);
            chk("busy", 32'(busy), 1);
            chk("arr_reset", 32'(arr_reset), 32'(cyc == 1));
            chk("w_valid", 32'(w_valid), 32'(in_valid && in_ready));
            chk("arr_l_d_i", 32'(arr_l_d_i), (in_valid && in_ready) ? 32'(in_data) : 0);
            chk("arr_read", 32'(arr_read), 32'(out_valid && out_ready));
            if (in_ready) chk("w_row", 32'(w_row), 32'(si));
            if (stall) chk("stall_hold", 32'(out_data), 32'(prev));
            if (in_ready) fc++;
            if (out_valid) rc++;
            if (busy && !arr_reset && !in_ready && !out_valid && !done) dc++;
            if (in_valid && in_ready) si++;
            stall = out_valid && !out_ready;
            prev = out_data;
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 0;
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        chk("feed_cycles", 32'(fc), 32'(exp_feed));
        chk("drain_cycles", 32'(dc), 3);
        chk("read_cycles", 32'(rc), 32'(exp_read));
    endtask

    initial begin
        reset = 1; start = 0; len = 0; in_valid = 1; in_data = 16'h1234; out_ready = 1;
        vmask = '1; rmask = '1;
        for (int r = 0; r < 256; r++) wbuf[r] = 16'(r + 2);
        for (int i = 0; i < 8; i++) smp[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arr_reset", 32'(arr_reset), 1);
        chk("rst_outputs", {22'd0, busy, done, in_ready, w_valid, arr_read, out_valid, out_last, 3'd0}, 0);
        chk("rst_w_row", 32'(w_row), 0);
        chk("rst_l_d_i", 32'(arr_l_d_i), 0);
        @(posedge clk); #1;
        reset = 0; in_valid = 0;
        // basic: samples 1,2,3 * weights 2,3,4 = 20
        smp[0] = 1; smp[1] = 2; smp[2] = 3;
        job(8'd3, 16'd20, 12, 3, 4, 0);
        // bubble on second feed cycle: 5*2 + 6*3 + 7*4 = 56
        smp[0] = 5; smp[1] = 6; smp[2] = 7; vmask = 32'hffff_fffd;
        job(8'd3, 16'd56, 13, 4, 4, 0);
        vmask = '1;
        // backpressure 1,0,0,1,1,1: 1*2 + 1*3 = 5
        smp[0] = 1; smp[1] = 1; rmask = 32'hffff_fff9;
        job(8'd2, 16'd5, 13, 2, 6, 0);
        rmask = '1;
        job(8'd0, 16'd0, 9, 0, 4, 0);
        // start pokes during FEED and READ: 2*2 + 2*3 + 2*4 = 18
        smp[0] = 2; smp[1] = 2; smp[2] = 2;
        job(8'd3, 16'd18, 12, 3, 4, 1);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("poke_ignored", {30'd0, busy, done}, 0);
        end
        // reset in second FEED cycle aborts the job
        @(posedge clk); #1;
        start = 1; len = 8'd3;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        in_valid = 1; in_data = 16'd9;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_arr_reset", 32'(arr_reset), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_next", {29'd0, busy, in_ready, done}, 0);
        chk("abort_next_arr_reset", 32'(arr_reset), 1);
        @(posedge clk); #1;
        reset = 0; in_valid = 0;
        begin
            bit act;
            act = 0;
            repeat (10) begin
                @(negedge clk);
                if (busy || done || out_valid) act = 1;
            end
            chk("abort_quiet", 32'(act), 0);
        end
        smp[0] = 1; smp[1] = 2; smp[2] = 3;
        job(8'd3, 16'd20, 12, 3, 4, 0);
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
